// File: rtl/mult_rs_array_pkg.sv
// Shared definitions for the multiply reservation station: RV32M funct3
// encodings, the entry record and the result record handed to the CDB side.
package mult_rs_array_pkg;

  localparam logic [2:0] MUL_F3_MUL    = 3'b000;
  localparam logic [2:0] MUL_F3_MULH   = 3'b001;
  localparam logic [2:0] MUL_F3_MULHSU = 3'b010;
  localparam logic [2:0] MUL_F3_MULHU  = 3'b011;

  localparam int RS_TAG_W = 5;
  localparam int RS_XLEN  = 32;

  typedef struct packed {
    logic                valid;
    logic [RS_TAG_W-1:0] dest;
    logic [RS_TAG_W-1:0] tag1;
    logic [RS_TAG_W-1:0] tag2;
    logic [RS_XLEN-1:0]  src1;
    logic [RS_XLEN-1:0]  src2;
    logic [2:0]          funct3;
  } rs_entry_t;

  // Same layout as the command_buffer result record: tag then value.
  typedef struct packed {
    logic [RS_TAG_W-1:0] dest;
    logic [RS_XLEN-1:0]  data;
  } mul_result_t;

endpackage

// File: rtl/mult_rs_array_mul_pipe.sv
// MUL_LAT-stage RV32M multiplier. The product is formed ahead of the first
// register and then delayed; retiming is expected to spread the multiply.
// The whole pipe freezes when advance is low.
module mul_pipe
  import mult_rs_array_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             advance,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [2:0]       funct3,
  input  logic [TAG_W-1:0] in_dest,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_dest,
  output logic [XLEN-1:0]  out_data
);
  localparam int PW = 2*XLEN + 2;

  logic                    a_sgn, b_sgn;
  logic signed [XLEN:0]    a_ext, b_ext;
  logic signed [PW-1:0]    a_w, b_w, prod;
  logic [XLEN-1:0]         res;
  logic                    prod_unused;

  logic [MUL_LAT:1]        vld_pipe;
  logic [TAG_W-1:0]        dst_pipe [MUL_LAT:1];
  logic [XLEN-1:0]         dat_pipe [MUL_LAT:1];

  // Extend operands to 33 bits by funct3 and pick the product half.
  always_comb begin
    a_sgn = (funct3 == MUL_F3_MULH) || (funct3 == MUL_F3_MULHSU);
    b_sgn = (funct3 == MUL_F3_MULH);
    a_ext = {a_sgn & a[XLEN-1], a};
    b_ext = {b_sgn & b[XLEN-1], b};
    a_w   = PW'(a_ext);
    b_w   = PW'(b_ext);
    prod  = a_w * b_w;
    res   = '0;
    if (!funct3[2])
      res = (funct3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end
  assign prod_unused = ^prod[PW-1:2*XLEN];

  // Shift register of valid/dest/data; bubbles carry zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || flush) begin
      vld_pipe <= '0;
      for (int s = 1; s <= MUL_LAT; s++) begin
        dst_pipe[s] <= '0;
        dat_pipe[s] <= '0;
      end
    end else if (advance) begin
      vld_pipe[1] <= in_valid;
      dst_pipe[1] <= in_valid ? in_dest : '0;
      dat_pipe[1] <= in_valid ? res : '0;
      for (int s = 2; s <= MUL_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        dst_pipe[s] <= dst_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign out_valid = vld_pipe[MUL_LAT];
  assign out_dest  = dst_pipe[MUL_LAT];
  assign out_data  = dat_pipe[MUL_LAT];

endmodule

// File: rtl/mult_rs_array.sv
// Multiply reservation station: holds dispatched RV32M ops, wakes operands
// from the CDBs and its own result port, and issues the oldest ready entry
// into mul_pipe. Age is tracked with a matrix: older[i][j] = i before j.
module mult_rs_array
  import mult_rs_array_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int NUM_CDB     = 3,
  parameter int TAG_W       = 5,
  parameter int XLEN        = 32,
  parameter int MUL_LAT     = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [TAG_W-1:0]         alloc_dest,
  input  logic [TAG_W-1:0]         alloc_tag1,
  input  logic [TAG_W-1:0]         alloc_tag2,
  input  logic [XLEN-1:0]          alloc_src1,
  input  logic [XLEN-1:0]          alloc_src2,
  input  logic [2:0]               alloc_funct3,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [TAG_W-1:0]         res_dest,
  output logic [XLEN-1:0]          res_data,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] free_count
);
  localparam int CW = $clog2(NUM_ENTRIES+1);

  logic [NUM_ENTRIES-1:0] e_valid;
  logic [TAG_W-1:0]       e_dest [NUM_ENTRIES];
  logic [TAG_W-1:0]       e_tag1 [NUM_ENTRIES];
  logic [TAG_W-1:0]       e_tag2 [NUM_ENTRIES];
  logic [XLEN-1:0]        e_src1 [NUM_ENTRIES];
  logic [XLEN-1:0]        e_src2 [NUM_ENTRIES];
  logic [2:0]             e_f3   [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] older  [NUM_ENTRIES];

  logic [XLEN:0]          wk1 [NUM_ENTRIES];
  logic [XLEN:0]          wk2 [NUM_ENTRIES];
  logic [XLEN:0]          a_wk1, a_wk2;
  logic [NUM_ENTRIES-1:0] ready, sel, alloc_oh;
  logic                   int_v, advance, issue, alloc_fire;
  logic [XLEN-1:0]        iss_src1, iss_src2;
  logic [TAG_W-1:0]       iss_dest;
  logic [2:0]             iss_f3;
  logic [CW-1:0]          cnt;

  // Returns {hit, data}; lowest cdb index wins, internal result bus last.
  function automatic logic [XLEN:0] snoop(
    input logic [TAG_W-1:0]         t,
    input logic [NUM_CDB-1:0]       v,
    input logic [NUM_CDB*TAG_W-1:0] tg,
    input logic [NUM_CDB*XLEN-1:0]  d,
    input logic                     iv,
    input logic [TAG_W-1:0]         it,
    input logic [XLEN-1:0]          id);
    logic [XLEN:0] r;
    r = '0;
    if (t != '0) begin
      if (iv && it == t) r = {1'b1, id};
      for (int b = NUM_CDB-1; b >= 0; b--)
        if (v[b] && tg[b*TAG_W +: TAG_W] == t) r = {1'b1, d[b*XLEN +: XLEN]};
    end
    return r;
  endfunction

  assign int_v      = res_valid && res_ready;
  assign advance    = !(res_valid && !res_ready);
  assign alloc_ready = ~&e_valid;
  assign alloc_fire = alloc_valid && alloc_ready && !flush;
  assign issue      = advance && |ready;
  assign free_count = cnt;

  // Operand wakeup for held entries and for the op being dispatched.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      wk1[i] = snoop(e_tag1[i], cdb_valid, cdb_tag, cdb_data, int_v, res_dest, res_data);
      wk2[i] = snoop(e_tag2[i], cdb_valid, cdb_tag, cdb_data, int_v, res_dest, res_data);
    end
    a_wk1 = snoop(alloc_tag1, cdb_valid, cdb_tag, cdb_data, int_v, res_dest, res_data);
    a_wk2 = snoop(alloc_tag2, cdb_valid, cdb_tag, cdb_data, int_v, res_dest, res_data);
  end

  // Oldest-ready select, lowest free slot, free count and issue operand mux.
  always_comb begin
    cnt      = '0;
    alloc_oh = '0;
    iss_src1 = '0;
    iss_src2 = '0;
    iss_dest = '0;
    iss_f3   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      ready[i] = e_valid[i] && e_tag1[i] == '0 && e_tag2[i] == '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      sel[i] = ready[i];
      for (int j = 0; j < NUM_ENTRIES; j++)
        if (ready[j] && older[j][i]) sel[i] = 1'b0;
    end
    for (int i = NUM_ENTRIES-1; i >= 0; i--)
      if (!e_valid[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!e_valid[i]) cnt = cnt + CW'(1);
      if (sel[i]) begin
        iss_src1 = iss_src1 | e_src1[i];
        iss_src2 = iss_src2 | e_src2[i];
        iss_dest = iss_dest | e_dest[i];
        iss_f3   = iss_f3   | e_f3[i];
      end
    end
  end

  // Entry state: allocate into free slots, wake, free on issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_valid <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        e_dest[i] <= '0; e_tag1[i] <= '0; e_tag2[i] <= '0;
        e_src1[i] <= '0; e_src2[i] <= '0; e_f3[i]   <= '0;
      end
    end else if (flush) begin
      e_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (e_valid[i]) begin
          if (issue && sel[i]) e_valid[i] <= 1'b0;
          if (wk1[i][XLEN]) begin e_tag1[i] <= '0; e_src1[i] <= wk1[i][XLEN-1:0]; end
          if (wk2[i][XLEN]) begin e_tag2[i] <= '0; e_src2[i] <= wk2[i][XLEN-1:0]; end
        end else if (alloc_fire && alloc_oh[i]) begin
          e_valid[i] <= 1'b1;
          e_dest[i]  <= alloc_dest;
          e_f3[i]    <= alloc_funct3;
          e_tag1[i]  <= a_wk1[XLEN] ? '0 : alloc_tag1;
          e_tag2[i]  <= a_wk2[XLEN] ? '0 : alloc_tag2;
          e_src1[i]  <= a_wk1[XLEN] ? a_wk1[XLEN-1:0] : alloc_src1;
          e_src2[i]  <= a_wk2[XLEN] ? a_wk2[XLEN-1:0] : alloc_src2;
        end
      end
    end
  end

  // Age matrix: a new entry is younger than every entry valid at dispatch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) older[i] <= '0;
    end else if (alloc_fire) begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        for (int j = 0; j < NUM_ENTRIES; j++)
          if (alloc_oh[j])      older[i][j] <= e_valid[i];
          else if (alloc_oh[i]) older[i][j] <= 1'b0;
    end
  end

  mul_pipe #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) u_mul (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (issue),
    .advance  (advance),
    .a        (iss_src1),
    .b        (iss_src2),
    .funct3   (iss_f3),
    .in_dest  (iss_dest),
    .out_valid(res_valid),
    .out_dest (res_dest),
    .out_data (res_data)
  );

endmodule

// File: tb/tb_mult_rs_array.sv
// Directed bench for mult_rs_array: a table of ready-operand ops with
// hand-computed results, then sequences for wakeup, ordering, stall,
// flush and asynchronous reset.
module tb_mult_rs_array;
  localparam int NE = 4, NC = 3, TW = 5, XL = 32, ML = 3;

  logic clk = 0, reset_n = 0, flush = 0;
  logic alloc_valid = 0, alloc_ready;
  logic [TW-1:0] alloc_dest = 0, alloc_tag1 = 0, alloc_tag2 = 0;
  logic [XL-1:0] alloc_src1 = 0, alloc_src2 = 0;
  logic [2:0] alloc_funct3 = 0;
  logic [NC-1:0] cdb_valid = 0;
  logic [NC*TW-1:0] cdb_tag = 0;
  logic [NC*XL-1:0] cdb_data = 0;
  logic res_valid, res_ready = 1;
  logic [TW-1:0] res_dest;
  logic [XL-1:0] res_data;
  logic [$clog2(NE+1)-1:0] free_count;

  int tests = 0, fails = 0;

  mult_rs_array #(.NUM_ENTRIES(NE), .NUM_CDB(NC), .TAG_W(TW), .XLEN(XL), .MUL_LAT(ML)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_dest(alloc_dest),
    .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2),
    .alloc_src1(alloc_src1), .alloc_src2(alloc_src2), .alloc_funct3(alloc_funct3),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_dest(res_dest),
    .res_data(res_data), .free_count(free_count));

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [31:0] s1, s2;
    logic [2:0] f3;
    logic [4:0] dest;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic alloc_set(input logic [4:0] d, input logic [4:0] t1, input logic [4:0] t2,
                           input logic [31:0] s1, input logic [31:0] s2, input logic [2:0] f3);
    alloc_valid = 1; alloc_dest = d; alloc_tag1 = t1; alloc_tag2 = t2;
    alloc_src1 = s1; alloc_src2 = s2; alloc_funct3 = f3;
  endtask

  task automatic clr_alloc();
    alloc_valid = 0; alloc_tag1 = 0; alloc_tag2 = 0;
  endtask

  task automatic cdb_set(input int b, input logic [4:0] t, input logic [31:0] d);
    cdb_valid[b] = 1; cdb_tag[b*TW +: TW] = t; cdb_data[b*XL +: XL] = d;
  endtask

  // Steps until res_valid or the budget runs out; timeout counts as a failure.
  task automatic wait_res(input string name, input int max, output int n);
    n = 0;
    while (!res_valid && n < max) begin step(); n++; end
    if (!res_valid) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n, seen;
    vecs[0] = '{"mul_7x6",      32'd7,        32'd6,        3'b000, 5'd9,  32'd42};
    vecs[1] = '{"mulh_m1x2",    32'hFFFFFFFF, 32'd2,        3'b001, 5'd10, 32'hFFFFFFFF};
    vecs[2] = '{"mulhsu_m1x2",  32'hFFFFFFFF, 32'd2,        3'b010, 5'd11, 32'hFFFFFFFF};
    vecs[3] = '{"mulhu_m1x2",   32'hFFFFFFFF, 32'd2,        3'b011, 5'd12, 32'h00000001};
    vecs[4] = '{"mulh_min2",    32'h80000000, 32'h80000000, 3'b001, 5'd13, 32'h40000000};
    vecs[5] = '{"mulhu_min2",   32'h80000000, 32'h80000000, 3'b011, 5'd14, 32'h40000000};
    vecs[6] = '{"mulhsu_min2",  32'h80000000, 32'h80000000, 3'b010, 5'd15, 32'hC0000000};
    vecs[7] = '{"mul_low_m1sq", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 5'd16, 32'h00000001};
    vecs[8] = '{"div_f3_zero",  32'h12345678, 32'h10,       3'b100, 5'd17, 32'h0};

    // reset state
    step(); step();
    reset_n = 1;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_dest", res_dest, 0);
    check("rst_res_data", res_data, 0);
    check("rst_free_count", free_count, NE);
    check("rst_alloc_ready", alloc_ready, 1);

    // table: ready operands, latency MUL_LAT from the accept edge
    foreach (vecs[k]) begin
      alloc_set(vecs[k].dest, 0, 0, vecs[k].s1, vecs[k].s2, vecs[k].f3);
      step(); clr_alloc();
      wait_res(vecs[k].name, 8, n);
      check({vecs[k].name, "_lat"}, n, ML);
      check({vecs[k].name, "_dest"}, res_dest, vecs[k].dest);
      check({vecs[k].name, "_data"}, res_data, vecs[k].exp);
    end
    step();
    check("table_drain", res_valid, 0);

    // wakeup from cdb bus 1 two cycles after dispatch
    alloc_set(5, 4, 0, 0, 3, 3'b000);
    step(); clr_alloc();
    step();
    check("wk_waiting_free", free_count, NE-1);
    check("wk_no_early_res", res_valid, 0);
    cdb_set(1, 4, 10);
    step(); cdb_valid = 0;
    wait_res("wk_cdb", 8, n);
    check("wk_cdb_dest", res_dest, 5);
    check("wk_cdb_data", res_data, 30);
    step();

    // alloc and cdb match in the same cycle: same latency as a ready op
    alloc_set(7, 6, 0, 0, 5, 3'b000);
    cdb_set(0, 6, 4);
    step(); clr_alloc(); cdb_valid = 0;
    wait_res("wk_same", 8, n);
    check("wk_same_lat", n, ML);
    check("wk_same_data", res_data, 20);
    step();

    // wakeup from the internal result bus
    alloc_set(15, 0, 0, 3, 4, 3'b000);
    step();
    alloc_set(16, 15, 0, 0, 2, 3'b000);
    step(); clr_alloc();
    wait_res("int_a", 8, n);
    check("int_a_dest", res_dest, 15);
    check("int_a_data", res_data, 12);
    step();
    wait_res("int_b", 8, n);
    check("int_b_dest", res_dest, 16);
    check("int_b_data", res_data, 24);
    step();

    // fill, then release in allocation order
    for (int i = 0; i < NE; i++) begin
      alloc_set(5'(11 + i), 8, 0, 0, 32'(i + 1), 3'b000);
      step();
    end
    check("full_alloc_ready", alloc_ready, 0);
    check("full_free_count", free_count, 0);
    alloc_set(20, 0, 0, 1, 1, 3'b000);
    step();
    check("full_ignored", free_count, 0);
    cdb_set(2, 8, 10);
    step(); cdb_valid = 0; clr_alloc();
    wait_res("age", 8, n);
    for (int i = 0; i < NE; i++) begin
      check($sformatf("age_dest%0d", i), {res_valid, res_dest}, {1'b1, 5'(11 + i)});
      check($sformatf("age_data%0d", i), res_data, 32'(10 * (i + 1)));
      step();
    end
    check("age_no_extra", res_valid, 0);

    // backpressure: three in flight, held for five cycles
    res_ready = 0;
    for (int i = 0; i < 3; i++) begin
      alloc_set(5'(21 + i), 0, 0, 32'(i + 2), 3, 3'b000);
      step();
    end
    clr_alloc();
    wait_res("bp", 8, n);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d", i), {res_valid, res_dest, res_data}, {1'b1, 5'd21, 32'd6});
      step();
    end
    res_ready = 1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_rel%0d", i), {res_valid, res_dest, res_data},
            {1'b1, 5'(21 + i), 32'(3 * (i + 2))});
      step();
    end
    check("bp_drain", res_valid, 0);

    // flush with two waiting entries and two in flight; same-cycle alloc dropped
    alloc_set(1, 0, 0, 2, 2, 3'b000); step();
    alloc_set(2, 0, 0, 3, 3, 3'b000); step();
    alloc_set(3, 30, 0, 0, 1, 3'b000); step();
    alloc_set(4, 30, 0, 0, 1, 3'b000); step();
    check("fl_pre_free", free_count, 2);
    flush = 1;
    alloc_set(5, 0, 0, 1, 1, 3'b000);
    step(); flush = 0; clr_alloc();
    check("fl_res_valid", res_valid, 0);
    check("fl_free_count", free_count, NE);
    seen = 0;
    repeat (6) begin step(); if (res_valid) seen++; end
    check("fl_quiet", seen, 0);

    // asynchronous reset while a result is held
    alloc_set(3, 0, 0, 7, 7, 3'b000); step();
    alloc_set(4, 9, 0, 0, 1, 3'b000); step();
    clr_alloc();
    res_ready = 0;
    wait_res("rst_mid", 8, n);
    check("rst_mid_pre", res_data, 49);
    #2 reset_n = 0;
    #1;
    check("rst_async_out", {res_valid, res_dest, res_data}, 0);
    check("rst_async_free", free_count, NE);
    check("rst_async_ready", alloc_ready, 1);
    #1 reset_n = 1;
    res_ready = 1;
    seen = 0;
    repeat (5) begin step(); if (res_valid) seen++; end
    check("rst_quiet", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
